// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, FSM states and round/saturate helper for the FIR MAC sequencer
package fir_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_REGS   = 8;
    localparam int Q_FORMAT   = 8;
    localparam int PTR_WIDTH  = $clog2(NUM_REGS);
    // Wide enough that NUM_REGS full-scale products never overflow
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + PTR_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(64'sd1 <<< (Q_FORMAT - 1));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX    = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN    = ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    // Round half up at the Q point, then clamp into the signed result range
    function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] rounded;
        rounded = (acc + ROUND_BIAS) >>> Q_FORMAT;
        if (rounded > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (rounded < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            return rounded[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - single multiply-accumulate stage with rounded, saturated view of the next sum
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] coef,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] result_next
);

    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    acc_next;

    assign product     = (2*DATA_WIDTH)'(coef) * (2*DATA_WIDTH)'(sample);
    assign acc_next    = acc + $signed({{PTR_WIDTH{product[2*DATA_WIDTH-1]}}, product});
    // The final tap's sum is rounded here so the top can capture it on the same edge
    assign result_next = round_sat(acc_next);

    // Accumulator: clear wins over enable so a fresh sample always starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR controller: delay line, tap sequencing and handshakes
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                accelerateEn,
    input  logic                                clear,
    input  logic signed [DATA_WIDTH-1:0]        sampleIn,
    input  logic                                sampleValid,
    output logic                                sampleReady,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] coefs,
    output logic signed [DATA_WIDTH-1:0]        macResult,
    output logic                                resultIsValid,
    input  logic                                resultReady,
    output logic                                busy,
    output logic                                filled
);

    state_t state;
    state_t state_next;

    logic signed [DATA_WIDTH-1:0] delay_line [NUM_REGS];
    logic [PTR_WIDTH-1:0]         wr_ptr;
    logic [PTR_WIDTH-1:0]         newest;
    logic [PTR_WIDTH-1:0]         tap;
    logic [PTR_WIDTH-1:0]         rd_idx;
    logic [PTR_WIDTH:0]           count;
    logic                         accept;
    logic                         mac_step;
    logic                         last_tap;
    logic signed [DATA_WIDTH-1:0] result_next;

    assign sampleReady = (state == ST_IDLE) && accelerateEn && !clear;
    assign accept      = sampleValid && sampleReady;
    assign mac_step    = (state == ST_MAC) && accelerateEn && !clear;
    assign last_tap    = (tap == PTR_WIDTH'(NUM_REGS - 1));
    // Modular subtraction walks backwards from the newest sample
    assign rd_idx      = newest - tap;
    assign busy        = (state != ST_IDLE);
    assign filled      = (count == (PTR_WIDTH+1)'(NUM_REGS));

    fir_mac_unit u_mac (
        .clk         (clk),
        .rst         (rst),
        .clr         (clear || accept),
        .en          (mac_step),
        .coef        ($signed(coefs[tap])),
        .sample      (delay_line[rd_idx]),
        .result_next (result_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides every state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)               state_next = ST_MAC;
            ST_MAC:  if (mac_step && last_tap) state_next = ST_OUT;
            ST_OUT:  if (resultReady)          state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    // Delay line, write pointer and saturating fill counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) delay_line[i] <= '0;
            wr_ptr <= '0;
            newest <= '0;
            count  <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) delay_line[i] <= '0;
            wr_ptr <= '0;
            newest <= '0;
            count  <= '0;
        end else if (accept) begin
            delay_line[wr_ptr] <= sampleIn;
            newest             <= wr_ptr;
            wr_ptr             <= wr_ptr + 1'b1;
            if (!filled) begin
                count <= count + 1'b1;
            end
        end
    end

    // Tap index: restarts on accept, advances only on enabled MAC cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap <= '0;
        end else if (clear || accept) begin
            tap <= '0;
        end else if (mac_step) begin
            tap <= tap + 1'b1;
        end
    end

    // Result register: captured on the last tap, held through OUT until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            macResult     <= '0;
            resultIsValid <= 1'b0;
        end else if (clear) begin
            resultIsValid <= 1'b0;
        end else if (mac_step && last_tap) begin
            macResult     <= result_next;
            resultIsValid <= 1'b1;
        end else if (state == ST_OUT && resultReady) begin
            resultIsValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - scoreboard bench for fir_mac_sequencer
module tb_fir_mac_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               accelerateEn;
    logic               clear;
    logic signed [15:0] sampleIn;
    logic               sampleValid;
    logic               sampleReady;
    logic [7:0][15:0]   coefs;
    logic signed [15:0] macResult;
    logic               resultIsValid;
    logic               resultReady;
    logic               busy;
    logic               filled;

    int tests_run    = 0;
    int tests_failed = 0;

    logic signed [15:0] exp_q [$];
    logic signed [15:0] model_line [8];
    int                 model_wr;
    int                 model_newest;

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .accelerateEn  (accelerateEn),
        .clear         (clear),
        .sampleIn      (sampleIn),
        .sampleValid   (sampleValid),
        .sampleReady   (sampleReady),
        .coefs         (coefs),
        .macResult     (macResult),
        .resultIsValid (resultIsValid),
        .resultReady   (resultReady),
        .busy          (busy),
        .filled        (filled)
    );

    function automatic logic signed [15:0] model_result();
        longint acc = 0;
        longint r;
        for (int i = 0; i < 8; i++) begin
            int idx = (model_newest - i) & 7;
            acc += longint'($signed(coefs[i])) * longint'(model_line[idx]);
        end
        r = (acc + 128) >>> 8;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_line[i] = '0;
        model_wr     = 0;
        model_newest = 0;
    endtask

    task automatic set_coefs(input logic [15:0] c);
        for (int i = 0; i < 8; i++) coefs[i] = c;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; sampleValid = 1'b0; resultReady = 1'b0; accelerateEn = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    // Waits (bounded) for sampleReady, then presents one sample for exactly one edge
    task automatic send(input logic signed [15:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sampleReady) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            sampleIn = v; sampleValid = 1'b1;
            @(posedge clk);
            model_line[model_wr] = v;
            model_newest = model_wr;
            model_wr = (model_wr + 1) & 7;
            exp_q.push_back(model_result());
            #1 sampleValid = 1'b0;
        end
    endtask

    // Counts edges after the accept until resultIsValid, optionally stalling accelerateEn
    task automatic collect(input int stall_at, input int stall_len, input bit release_out,
                           output logic signed [15:0] res, output int lat, output bit ok);
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == stall_at) accelerateEn = 1'b0;
            if (lat == stall_at + stall_len) accelerateEn = 1'b1;
            if (resultIsValid) begin ok = 1'b1; break; end
        end
        accelerateEn = 1'b1;
        res = macResult;
        if (ok && release_out) begin
            resultReady = 1'b1;
            @(posedge clk); #1;
            resultReady = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; sampleValid = 1'b0; resultReady = 1'b0; accelerateEn = 1'b1;
        sampleIn = '0; set_coefs(16'd0);
        @(posedge clk); #1;
        tests_run++;
        if (macResult !== 16'sd0 || resultIsValid !== 1'b0 || busy !== 1'b0 || filled !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got res=%0d v=%b busy=%b filled=%b want 0 0 0 0",
                     macResult, resultIsValid, busy, filled);
        end
        tests_run++;
        if (sampleReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sample_ready: got %b want 1", sampleReady);
        end
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    task automatic test_single();
        bit ok; int lat; logic signed [15:0] res, exp_v;
        do_reset();
        set_coefs(16'd51);
        send(16'sd256, ok);
        collect(0, 0, 1'b1, res, lat, ok);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (!ok || lat != 8) begin
            tests_failed++;
            $display("FAIL single_latency: got ok=%b lat=%0d want 8", ok, lat);
        end
        tests_run++;
        if (res !== exp_v || res !== 16'sd51) begin
            tests_failed++;
            $display("FAIL single_result: got %0d want %0d (model %0d)", res, 51, exp_v);
        end
        tests_run++;
        if (filled !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_filled: got %b want 0", filled);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; logic signed [15:0] res, exp_v;
        do_reset();
        set_coefs(16'd51);
        for (int k = 0; k < 9; k++) begin
            send((k < 8) ? 16'sd1024 : 16'sd0, ok);
            tests_run++;
            if (filled !== (k >= 7)) begin
                tests_failed++;
                $display("FAIL b2b_filled[%0d]: got %b want %b", k, filled, (k >= 7));
            end
            collect(0, 0, 1'b1, res, lat, ok);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (!ok || res !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_result[%0d]: got %0d want %0d (ok=%b)", k, res, exp_v, ok);
            end
            if (k == 7) begin
                tests_run++;
                if (res !== 16'sd1632) begin
                    tests_failed++;
                    $display("FAIL b2b_eighth: got %0d want 1632", res);
                end
            end
            if (k == 8) begin
                tests_run++;
                if (res !== 16'sd1428) begin
                    tests_failed++;
                    $display("FAIL b2b_wrap: got %0d want 1428", res);
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit ok; int lat; logic signed [15:0] res, exp_v;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            set_coefs(16'h7FFF);
            for (int k = 0; k < 8; k++) begin
                send((pass == 0) ? 16'sh7FFF : 16'sh8000, ok);
                collect(0, 0, 1'b1, res, lat, ok);
                exp_v = exp_q.pop_front();
                tests_run++;
                if (!ok || res !== exp_v) begin
                    tests_failed++;
                    $display("FAIL sat%0d_result[%0d]: got %0d want %0d", pass, k, res, exp_v);
                end
            end
            tests_run++;
            if (res !== ((pass == 0) ? 16'sh7FFF : 16'sh8000)) begin
                tests_failed++;
                $display("FAIL sat%0d_final: got %h want %h", pass, res,
                         (pass == 0) ? 16'h7FFF : 16'h8000);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic signed [15:0] res, exp_v;
        do_reset();
        set_coefs(16'd51);
        send(16'sd512, ok);
        collect(0, 0, 1'b0, res, lat, ok);
        sampleIn = 16'sd1000; sampleValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (resultIsValid !== 1'b1 || macResult !== res || sampleReady !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b res=%0d rdy=%b busy=%b want 1 %0d 0 1",
                         c, resultIsValid, macResult, sampleReady, busy, res);
            end
        end
        sampleValid = 1'b0;
        resultReady = 1'b1;
        @(posedge clk); #1;
        resultReady = 1'b0;
        tests_run++;
        if (resultIsValid !== 1'b0 || busy !== 1'b0 || sampleReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: got v=%b busy=%b rdy=%b want 0 0 1", resultIsValid, busy, sampleReady);
        end
        exp_v = exp_q.pop_front();
        tests_run++;
        if (res !== exp_v) begin
            tests_failed++;
            $display("FAIL bp_result: got %0d want %0d", res, exp_v);
        end
        send(16'sd256, ok);
        collect(0, 0, 1'b1, res, lat, ok);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (!ok || res !== exp_v) begin
            tests_failed++;
            $display("FAIL bp_ignored_sample: got %0d want %0d", res, exp_v);
        end
    endtask

    task automatic test_stall();
        bit ok; int lat; logic signed [15:0] res, exp_v;
        do_reset();
        set_coefs(16'd51);
        send(16'sd256, ok);
        collect(2, 3, 1'b1, res, lat, ok);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (!ok || lat != 11) begin
            tests_failed++;
            $display("FAIL stall_latency: got ok=%b lat=%0d want 11", ok, lat);
        end
        tests_run++;
        if (res !== exp_v || res !== 16'sd51) begin
            tests_failed++;
            $display("FAIL stall_result: got %0d want 51", res);
        end
    endtask

    task automatic test_clear();
        bit ok; int lat; int seen; logic signed [15:0] res, exp_v;
        do_reset();
        set_coefs(16'd51);
        send(16'sd1024, ok);
        collect(0, 0, 1'b1, res, lat, ok);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (!ok || res !== exp_v) begin
            tests_failed++;
            $display("FAIL clear_pre_result: got %0d want %0d", res, exp_v);
        end
        send(16'sd1024, ok);
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        void'(exp_q.pop_back());
        model_reset();
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (resultIsValid) seen++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (seen != 0 || filled !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_flush: got valid_cycles=%0d filled=%b busy=%b want 0 0 0", seen, filled, busy);
        end
        send(16'sd256, ok);
        collect(0, 0, 1'b1, res, lat, ok);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (!ok || res !== exp_v || res !== 16'sd51) begin
            tests_failed++;
            $display("FAIL clear_post_result: got %0d want 51", res);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        tests_run++;
        if (macResult !== 16'sd51) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got %0d want 51", macResult);
        end
        send(16'sd256, ok);
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || resultIsValid !== 1'b0 || macResult !== 16'sd0 || filled !== 1'b0
            || sampleReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got busy=%b v=%b res=%0d filled=%b rdy=%b want 0 0 0 0 1",
                     busy, resultIsValid, macResult, filled, sampleReady);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_stall();
        test_clear();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
